// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the per-axis phase type used by the
// timing generator and its axis counters.
package vga_pkg;

   localparam int CNT_W        = 10;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;

   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   // Gray-coded so every phase step flips one bit and the sync/active decodes stay glitch-free
   typedef enum logic [1:0] {
      ACTIVE = 2'b00,
      FRONT  = 2'b01,
      SYNC   = 2'b11,
      BACK   = 2'b10
   } phase_t;

endpackage

// File: rtl/vga_axis.sv
// One timing axis: a wrapping position counter plus its ACTIVE/FRONT/SYNC/BACK
// phase register, both stepping only when advance is high.
module vga_axis
   import vga_pkg::*;
#(
   parameter int A_LEN = DEF_H_ACTIVE,
   parameter int F_LEN = DEF_H_FP,
   parameter int S_LEN = DEF_H_SYNC,
   parameter int B_LEN = DEF_H_BP
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             advance,
   output logic [CNT_W-1:0] count,
   output phase_t           phase,
   output logic             wrap
);

   localparam logic [CNT_W-1:0] C_FRONT = CNT_W'(A_LEN);
   localparam logic [CNT_W-1:0] C_SYNC  = CNT_W'(A_LEN + F_LEN);
   localparam logic [CNT_W-1:0] C_BACK  = CNT_W'(A_LEN + F_LEN + S_LEN);
   localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(A_LEN + F_LEN + S_LEN + B_LEN - 1);

   logic [CNT_W-1:0] r_count;
   phase_t           r_phase;
   logic [CNT_W-1:0] w_nxt_count;
   logic             w_wrap;

   assign w_wrap      = (r_count == C_LAST);
   assign w_nxt_count = w_wrap ? '0 : (r_count + CNT_W'(1));

   // Phase changes on entry to the first count of the following phase
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= C_LAST;
         r_phase <= BACK;
      end else if (advance) begin
         r_count <= w_nxt_count;
         if (w_nxt_count == '0) begin
            r_phase <= ACTIVE;
         end else if (w_nxt_count == C_FRONT) begin
            r_phase <= FRONT;
         end else if (w_nxt_count == C_SYNC) begin
            r_phase <= SYNC;
         end else if (w_nxt_count == C_BACK) begin
            r_phase <= BACK;
         end
      end
   end

   assign count = r_count;
   assign phase = r_phase;
   assign wrap  = w_wrap;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: horizontal and vertical axis counters with
// active-low syncs, visible-area flag and line/frame start pulses.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pix_en,
   output logic [CNT_W-1:0] hcount,
   output logic [CNT_W-1:0] vcount,
   output logic             hsync,
   output logic             vsync,
   output logic             active,
   output logic             frame_start,
   output logic             line_start
);

   phase_t w_h_phase;
   phase_t w_v_phase;
   logic   w_h_wrap;
   logic   w_v_wrap;
   logic   w_v_adv;
   logic   r_line_start;
   logic   r_frame_start;

   // The line steps only when the pixel counter leaves its last column
   assign w_v_adv = pix_en & w_h_wrap;

   vga_axis #(
      .A_LEN (H_ACTIVE),
      .F_LEN (H_FP),
      .S_LEN (H_SYNC),
      .B_LEN (H_BP)
   ) u_h_axis (
      .clk     (clk),
      .reset   (reset),
      .advance (pix_en),
      .count   (hcount),
      .phase   (w_h_phase),
      .wrap    (w_h_wrap)
   );

   vga_axis #(
      .A_LEN (V_ACTIVE),
      .F_LEN (V_FP),
      .S_LEN (V_SYNC),
      .B_LEN (V_BP)
   ) u_v_axis (
      .clk     (clk),
      .reset   (reset),
      .advance (w_v_adv),
      .count   (vcount),
      .phase   (w_v_phase),
      .wrap    (w_v_wrap)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_line_start  <= w_v_adv;
         r_frame_start <= w_v_adv & w_v_wrap;
      end
   end

   // Decodes of the phase flops only; nothing here depends on an input
   assign hsync       = (w_h_phase != SYNC);
   assign vsync       = (w_v_phase != SYNC);
   assign active      = (w_h_phase == ACTIVE) && (w_v_phase == ACTIVE);
   assign line_start  = r_line_start;
   assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance plus a shrunken-timing instance
// share one stimulus stream and are checked against a scoreboard every clock.
module tb_vga_timing_gen;

   localparam int S_HA = 8, S_HF = 2, S_HS = 3, S_HB = 2;
   localparam int S_VA = 6, S_VF = 2, S_VS = 2, S_VB = 3;

   typedef struct {
      logic [9:0] h;
      logic [9:0] v;
      logic       hs;
      logic       vs;
      logic       act;
      logic       fs;
      logic       ls;
   } obs_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       pix_en;
   logic [9:0] d0_h, d0_v, d1_h, d1_v;
   logic       d0_hs, d0_vs, d0_act, d0_fs, d0_ls;
   logic       d1_hs, d1_vs, d1_act, d1_fs, d1_ls;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   int   HA[2], HF[2], HS[2], HT[2], VA[2], VF[2], VS[2], VT[2];
   int   mh[2], mv[2];
   bit   mfs[2], mls[2];
   obs_t q0[$];
   obs_t q1[$];

   always #5 clk = ~clk;

   vga_timing_gen u_full (
      .clk (clk), .reset (reset), .pix_en (pix_en),
      .hcount (d0_h), .vcount (d0_v), .hsync (d0_hs), .vsync (d0_vs),
      .active (d0_act), .frame_start (d0_fs), .line_start (d0_ls)
   );

   vga_timing_gen #(
      .H_ACTIVE (S_HA), .H_FP (S_HF), .H_SYNC (S_HS), .H_BP (S_HB),
      .V_ACTIVE (S_VA), .V_FP (S_VF), .V_SYNC (S_VS), .V_BP (S_VB)
   ) u_small (
      .clk (clk), .reset (reset), .pix_en (pix_en),
      .hcount (d1_h), .vcount (d1_v), .hsync (d1_hs), .vsync (d1_vs),
      .active (d1_act), .frame_start (d1_fs), .line_start (d1_ls)
   );

   function automatic obs_t model_obs(input int i);
      obs_t e;
      e.h   = 10'(mh[i]);
      e.v   = 10'(mv[i]);
      e.hs  = !((mh[i] >= HA[i] + HF[i]) && (mh[i] < HA[i] + HF[i] + HS[i]));
      e.vs  = !((mv[i] >= VA[i] + VF[i]) && (mv[i] < VA[i] + VF[i] + VS[i]));
      e.act = (mh[i] < HA[i]) && (mv[i] < VA[i]);
      e.fs  = mfs[i];
      e.ls  = mls[i];
      return e;
   endfunction

   function automatic obs_t dut_obs(input int i);
      obs_t o;
      if (i == 0) begin
         o.h = d0_h; o.v = d0_v; o.hs = d0_hs; o.vs = d0_vs;
         o.act = d0_act; o.fs = d0_fs; o.ls = d0_ls;
      end else begin
         o.h = d1_h; o.v = d1_v; o.hs = d1_hs; o.vs = d1_vs;
         o.act = d1_act; o.fs = d1_fs; o.ls = d1_ls;
      end
      return o;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         mh[i] = HT[i] - 1; mv[i] = VT[i] - 1; mfs[i] = 1'b0; mls[i] = 1'b0;
      end
   endtask

   task automatic model_step(input bit en);
      for (int i = 0; i < 2; i++) begin
         if (en) begin
            mls[i] = (mh[i] == HT[i] - 1);
            mfs[i] = mls[i] && (mv[i] == VT[i] - 1);
            mh[i]  = mls[i] ? 0 : mh[i] + 1;
            if (mls[i]) mv[i] = (mv[i] == VT[i] - 1) ? 0 : mv[i] + 1;
         end else begin
            mfs[i] = 1'b0; mls[i] = 1'b0;
         end
      end
   endtask

   task automatic push_expected();
      q0.push_back(model_obs(0));
      q1.push_back(model_obs(1));
   endtask

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      n_cmp++;
      assert (o === e) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
      end
   endtask

   task automatic pop_check(input string tag);
      obs_t e, o;
      for (int i = 0; i < 2; i++) begin
         if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
            chk($sformatf("%s[%0d].queue_empty", tag, i), 32'd0, 32'd1);
         end else begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            o = dut_obs(i);
            chk($sformatf("%s[%0d].hcount", tag, i), 32'(o.h), 32'(e.h));
            chk($sformatf("%s[%0d].vcount", tag, i), 32'(o.v), 32'(e.v));
            chk($sformatf("%s[%0d].hsync", tag, i), 32'(o.hs), 32'(e.hs));
            chk($sformatf("%s[%0d].vsync", tag, i), 32'(o.vs), 32'(e.vs));
            chk($sformatf("%s[%0d].active", tag, i), 32'(o.act), 32'(e.act));
            chk($sformatf("%s[%0d].frame_start", tag, i), 32'(o.fs), 32'(e.fs));
            chk($sformatf("%s[%0d].line_start", tag, i), 32'(o.ls), 32'(e.ls));
         end
      end
   endtask

   task automatic tick(input bit en, input string tag);
      @(negedge clk);
      pix_en = en;
      model_step(en);
      push_expected();
      @(posedge clk);
      #1;
      cyc++;
      pop_check(tag);
   endtask

   initial begin
      int fs_seen;
      int t0;
      int t1;
      HA = '{640, S_HA}; HF = '{16, S_HF}; HS = '{96, S_HS};
      HT = '{800, S_HA + S_HF + S_HS + S_HB};
      VA = '{480, S_VA}; VF = '{10, S_VF}; VS = '{2, S_VS};
      VT = '{525, S_VA + S_VF + S_VS + S_VB};

      // Reset held with pix_en high: reset must dominate
      reset  = 1'b0;
      pix_en = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      push_expected();
      pop_check("reset");

      @(negedge clk);
      reset  = 1'b1;
      pix_en = 1'b0;

      tick(1'b1, "first_adv");
      tick(1'b0, "idle_after_first");
      for (int k = 0; k < 1000; k++) tick(1'b1, "continuous");

      // One advance in four; period measured on the small instance
      fs_seen = 0; t0 = 0; t1 = 0;
      for (int k = 0; k < 2400 && fs_seen < 2; k++) begin
         tick((k % 4) == 0, "quarter");
         if (d1_fs === 1'b1) begin
            if (fs_seen == 0) t0 = cyc;
            else t1 = cyc;
            fs_seen++;
         end
      end
      chk("frame_period_clks", (fs_seen == 2) ? 32'(t1 - t0) : 32'd0,
          32'(4 * HT[1] * VT[1]));

      for (int k = 0; k < 37; k++) tick(1'b1, "pre_async");

      // Reset dropped between edges must act before the next edge
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      model_reset();
      push_expected();
      pop_check("async_reset");

      @(negedge clk);
      pix_en = 1'b0;
      reset  = 1'b1;
      model_reset();
      tick(1'b0, "post_release_idle");
      tick(1'b1, "rerun_first");
      for (int k = 0; k < 300; k++) tick(1'b1, "rerun");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
